id_ex_alu_issue: RTL and testbench

- ID/EX pipeline register plus operand-issue logic of the pipelined MIPS core: the producer side of the ALU interface.
- Captures decoded fields at the end of ID and, in EX, drives DataA, DataB, Operation and BRANCH_EQ_NQ to the ALU.
- Resolves operand forwarding from EX/MEM and MEM/WB, immediate selection, and ALU-control decoding.
- Honours stall (hold) and flush (bubble) from the hazard unit.

---
 rtl/mips_alu_pkg.sv | 62 ++++++
 rtl/id_ex_alu_issue_fwd_mux.sv | 29 ++
 rtl/id_ex_alu_issue.sv | 135 +++++++++++++
 tb/tb_id_ex_alu_issue.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_alu_pkg.sv
// Shared ALU-control encodings for the ID/EX issue stage and the ALU.
// Pure constants plus the aluop/funct decode; no state.
package mips_alu_pkg;

    localparam logic [3:0] OP_AND = 4'b0000;
    localparam logic [3:0] OP_OR  = 4'b0001;
    localparam logic [3:0] OP_ADD = 4'b0010;
    localparam logic [3:0] OP_SUB = 4'b0110;
    localparam logic [3:0] OP_SLT = 4'b0111;
    localparam logic [3:0] OP_NOR = 4'b1100;

    localparam logic [5:0] FUNCT_ADD = 6'b100000;
    localparam logic [5:0] FUNCT_SUB = 6'b100010;
    localparam logic [5:0] FUNCT_AND = 6'b100100;
    localparam logic [5:0] FUNCT_OR  = 6'b100101;
    localparam logic [5:0] FUNCT_SLT = 6'b101010;
    localparam logic [5:0] FUNCT_NOR = 6'b100111;

    typedef enum logic [1:0] {
        ALUOP_ADD   = 2'b00,
        ALUOP_SUB   = 2'b01,
        ALUOP_FUNCT = 2'b10,
        ALUOP_OR    = 2'b11
    } aluop_e;

    localparam logic [1:0] BRANCH_EQ = 2'b00;
    localparam logic [1:0] BRANCH_NE = 2'b01;

    typedef struct packed {
        logic [3:0] op;
        logic       legal;
    } alu_ctl_t;

    // Unknown R-type funct decodes to add but is flagged so the caller can kill the write.
    function automatic alu_ctl_t decode_alu_ctl(input logic [1:0] aluop, input logic [5:0] funct);
        alu_ctl_t ctl;
        ctl.op    = OP_ADD;
        ctl.legal = 1'b1;
        case (aluop_e'(aluop))
            ALUOP_ADD: ctl.op = OP_ADD;
            ALUOP_SUB: ctl.op = OP_SUB;
            ALUOP_OR:  ctl.op = OP_OR;
            ALUOP_FUNCT: begin
                case (funct)
                    FUNCT_ADD: ctl.op = OP_ADD;
                    FUNCT_SUB: ctl.op = OP_SUB;
                    FUNCT_AND: ctl.op = OP_AND;
                    FUNCT_OR:  ctl.op = OP_OR;
                    FUNCT_SLT: ctl.op = OP_SLT;
                    FUNCT_NOR: ctl.op = OP_NOR;
                    default: begin
                        ctl.op    = OP_ADD;
                        ctl.legal = 1'b0;
                    end
                endcase
            end
            default: ctl.op = OP_ADD;
        endcase
        return ctl;
    endfunction

endpackage

// File: rtl/id_ex_alu_issue_fwd_mux.sv
// Operand forwarding select: EX/MEM over MEM/WB over the registered value, r0 never forwarded.
// Purely combinational, no state and no flow control.
module fwd_mux #(
    parameter int W  = 32,
    parameter int RW = 5
) (
    input  logic [RW-1:0] idx_i,
    input  logic [W-1:0]  reg_val_i,
    input  logic          exmem_regwrite_i,
    input  logic [RW-1:0] exmem_rd_i,
    input  logic [W-1:0]  exmem_result_i,
    input  logic          memwb_regwrite_i,
    input  logic [RW-1:0] memwb_rd_i,
    input  logic [W-1:0]  memwb_result_i,
    output logic [W-1:0]  fwd_val_o
);

    always_comb begin
        fwd_val_o = reg_val_i;
        if (idx_i != '0) begin
            if (exmem_regwrite_i && (exmem_rd_i == idx_i)) begin
                fwd_val_o = exmem_result_i;
            end else if (memwb_regwrite_i && (memwb_rd_i == idx_i)) begin
                fwd_val_o = memwb_result_i;
            end
        end
    end

endmodule

// File: rtl/id_ex_alu_issue.sv
// ID/EX register and ALU operand issue; one cycle from ID fields to ALU inputs.
// stall holds the register (operands still re-forward), flush loads a bubble and beats stall.
module id_ex_alu_issue
    import mips_alu_pkg::*;
#(
    parameter int W  = 32,
    parameter int RW = 5
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          stall,
    input  logic          flush,
    input  logic          id_valid,
    input  logic [W-1:0]  id_rs_val,
    input  logic [W-1:0]  id_rt_val,
    input  logic [RW-1:0] id_rs,
    input  logic [RW-1:0] id_rt,
    input  logic [RW-1:0] id_rd,
    input  logic [15:0]   id_imm16,
    input  logic [1:0]    id_aluop,
    input  logic [5:0]    id_funct,
    input  logic          id_alu_src,
    input  logic          id_zext,
    input  logic          id_branch_ne,
    input  logic          id_regwrite,
    input  logic          exmem_regwrite,
    input  logic          memwb_regwrite,
    input  logic [RW-1:0] exmem_rd,
    input  logic [RW-1:0] memwb_rd,
    input  logic [W-1:0]  exmem_result,
    input  logic [W-1:0]  memwb_result,
    output logic [W-1:0]  DataA,
    output logic [W-1:0]  DataB,
    output logic [3:0]    Operation,
    output logic [1:0]    BRANCH_EQ_NQ,
    output logic          ex_valid,
    output logic [RW-1:0] ex_rd,
    output logic          ex_regwrite,
    output logic [W-1:0]  ex_store_data
);

    logic          valid_q,    valid_d;
    logic [RW-1:0] rs_q,       rs_d;
    logic [RW-1:0] rt_q,       rt_d;
    logic [RW-1:0] rd_q,       rd_d;
    logic [W-1:0]  rs_val_q,   rs_val_d;
    logic [W-1:0]  rt_val_q,   rt_val_d;
    logic [W-1:0]  imm_q,      imm_d;
    logic          alu_src_q,  alu_src_d;
    logic [3:0]    op_q,       op_d;
    logic [1:0]    br_q,       br_d;
    logic          regwrite_q, regwrite_d;

    alu_ctl_t      ctl;
    logic [W-1:0]  fwd_rs;
    logic [W-1:0]  fwd_rt;

    always_comb begin
        ctl        = decode_alu_ctl(id_aluop, id_funct);
        valid_d    = id_valid;
        rs_d       = id_rs;
        rt_d       = id_rt;
        rd_d       = id_rd;
        rs_val_d   = id_rs_val;
        rt_val_d   = id_rt_val;
        imm_d      = id_zext ? {{(W-16){1'b0}}, id_imm16} : {{(W-16){id_imm16[15]}}, id_imm16};
        alu_src_d  = id_alu_src;
        op_d       = ctl.op;
        br_d       = id_branch_ne ? BRANCH_NE : BRANCH_EQ;
        // An undecodable funct must not corrupt the register file.
        regwrite_d = id_regwrite & ctl.legal;
    end

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            valid_q    <= 1'b0;
            rs_q       <= '0;
            rt_q       <= '0;
            rd_q       <= '0;
            rs_val_q   <= '0;
            rt_val_q   <= '0;
            imm_q      <= '0;
            alu_src_q  <= 1'b0;
            op_q       <= OP_ADD;
            br_q       <= BRANCH_EQ;
            regwrite_q <= 1'b0;
        end else if (!stall) begin
            valid_q    <= valid_d;
            rs_q       <= rs_d;
            rt_q       <= rt_d;
            rd_q       <= rd_d;
            rs_val_q   <= rs_val_d;
            rt_val_q   <= rt_val_d;
            imm_q      <= imm_d;
            alu_src_q  <= alu_src_d;
            op_q       <= op_d;
            br_q       <= br_d;
            regwrite_q <= regwrite_d;
        end
    end

    fwd_mux #(.W(W), .RW(RW)) u_fwd_rs (
        .idx_i            (rs_q),
        .reg_val_i        (rs_val_q),
        .exmem_regwrite_i (exmem_regwrite),
        .exmem_rd_i       (exmem_rd),
        .exmem_result_i   (exmem_result),
        .memwb_regwrite_i (memwb_regwrite),
        .memwb_rd_i       (memwb_rd),
        .memwb_result_i   (memwb_result),
        .fwd_val_o        (fwd_rs)
    );

    fwd_mux #(.W(W), .RW(RW)) u_fwd_rt (
        .idx_i            (rt_q),
        .reg_val_i        (rt_val_q),
        .exmem_regwrite_i (exmem_regwrite),
        .exmem_rd_i       (exmem_rd),
        .exmem_result_i   (exmem_result),
        .memwb_regwrite_i (memwb_regwrite),
        .memwb_rd_i       (memwb_rd),
        .memwb_result_i   (memwb_result),
        .fwd_val_o        (fwd_rt)
    );

    assign DataA         = fwd_rs;
    assign DataB         = alu_src_q ? imm_q : fwd_rt;
    assign ex_store_data = fwd_rt;
    assign Operation     = op_q;
    assign BRANCH_EQ_NQ  = br_q;
    assign ex_valid      = valid_q;
    assign ex_rd         = rd_q;
    assign ex_regwrite   = regwrite_q & valid_q;

endmodule

// File: tb/tb_id_ex_alu_issue.sv
// Randomised plus directed bench for id_ex_alu_issue with a queue-based scoreboard.
module tb_id_ex_alu_issue;

    logic        clk = 1'b0;
    logic        rst, stall, flush, id_valid;
    logic [31:0] id_rs_val, id_rt_val;
    logic [4:0]  id_rs, id_rt, id_rd;
    logic [15:0] id_imm16;
    logic [1:0]  id_aluop;
    logic [5:0]  id_funct;
    logic        id_alu_src, id_zext, id_branch_ne, id_regwrite;
    logic        exmem_regwrite, memwb_regwrite;
    logic [4:0]  exmem_rd, memwb_rd;
    logic [31:0] exmem_result, memwb_result;
    logic [31:0] DataA, DataB, ex_store_data;
    logic [3:0]  Operation;
    logic [1:0]  BRANCH_EQ_NQ;
    logic        ex_valid, ex_regwrite;
    logic [4:0]  ex_rd;

    always #5 clk = ~clk;

    id_ex_alu_issue #(.W(32), .RW(5)) dut (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush), .id_valid(id_valid),
        .id_rs_val(id_rs_val), .id_rt_val(id_rt_val), .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
        .id_imm16(id_imm16), .id_aluop(id_aluop), .id_funct(id_funct), .id_alu_src(id_alu_src),
        .id_zext(id_zext), .id_branch_ne(id_branch_ne), .id_regwrite(id_regwrite),
        .exmem_regwrite(exmem_regwrite), .memwb_regwrite(memwb_regwrite),
        .exmem_rd(exmem_rd), .memwb_rd(memwb_rd),
        .exmem_result(exmem_result), .memwb_result(memwb_result),
        .DataA(DataA), .DataB(DataB), .Operation(Operation), .BRANCH_EQ_NQ(BRANCH_EQ_NQ),
        .ex_valid(ex_valid), .ex_rd(ex_rd), .ex_regwrite(ex_regwrite), .ex_store_data(ex_store_data)
    );

    // Abstract view of the instruction sitting in EX.
    typedef struct {
        bit          valid;
        logic [4:0]  rs, rt, rd;
        logic [31:0] rs_val, rt_val, imm;
        bit          alu_src;
        logic [3:0]  op;
        logic [1:0]  br;
        bit          rw;
    } ex_instr_t;

    typedef struct {
        logic [31:0] a, b, sd;
        logic [3:0]  op;
        logic [1:0]  br;
        logic        v, rw;
        logic [4:0]  rd;
    } exp_t;

    ex_instr_t model;
    bit        model_known = 0;
    exp_t      exp_q[$];
    int        checks = 0;
    int        failures = 0;

    function automatic logic [3:0] ref_op(input logic [1:0] aluop, input logic [5:0] funct, output bit legal);
        legal = 1;
        if (aluop == 2'b00) return 4'b0010;
        if (aluop == 2'b01) return 4'b0110;
        if (aluop == 2'b11) return 4'b0001;
        case (funct)
            6'b100000: return 4'b0010;
            6'b100010: return 4'b0110;
            6'b100100: return 4'b0000;
            6'b100101: return 4'b0001;
            6'b101010: return 4'b0111;
            6'b100111: return 4'b1100;
            default: begin
                legal = 0;
                return 4'b0010;
            end
        endcase
    endfunction

    function automatic logic [31:0] ref_fwd(input logic [4:0] idx, input logic [31:0] regval);
        if (idx == 0) return regval;
        if (exmem_regwrite && exmem_rd == idx) return exmem_result;
        if (memwb_regwrite && memwb_rd == idx) return memwb_result;
        return regval;
    endfunction

    function automatic ex_instr_t bubble();
        ex_instr_t b;
        b.valid = 0; b.rs = 0; b.rt = 0; b.rd = 0;
        b.rs_val = 0; b.rt_val = 0; b.imm = 0; b.alu_src = 0;
        b.op = 4'b0010; b.br = 2'b00; b.rw = 0;
        return b;
    endfunction

    // Called at a falling edge with this cycle's inputs applied.
    task automatic cycle();
        exp_t e;
        bit   legal;
        if (model_known) begin
            e.a  = ref_fwd(model.rs, model.rs_val);
            e.sd = ref_fwd(model.rt, model.rt_val);
            e.b  = model.alu_src ? model.imm : e.sd;
            e.op = model.op;
            e.br = model.br;
            e.v  = model.valid;
            e.rw = model.rw && model.valid;
            e.rd = model.rd;
            exp_q.push_back(e);
        end
        @(posedge clk);
        if (rst || flush) begin
            model = bubble();
            if (rst) model_known = 1;
        end else if (!stall) begin
            model.valid   = id_valid;
            model.rs      = id_rs;
            model.rt      = id_rt;
            model.rd      = id_rd;
            model.rs_val  = id_rs_val;
            model.rt_val  = id_rt_val;
            model.imm     = id_zext ? {16'h0, id_imm16} : 32'($signed(id_imm16));
            model.alu_src = id_alu_src;
            model.op      = ref_op(id_aluop, id_funct, legal);
            model.br      = {1'b0, id_branch_ne};
            model.rw      = id_regwrite && legal;
        end
        @(negedge clk);
    endtask

    task automatic idle();
        rst = 0; stall = 0; flush = 0; id_valid = 0;
        id_rs_val = 0; id_rt_val = 0; id_rs = 0; id_rt = 0; id_rd = 0;
        id_imm16 = 0; id_aluop = 0; id_funct = 0; id_alu_src = 0; id_zext = 0;
        id_branch_ne = 0; id_regwrite = 0;
        exmem_regwrite = 0; memwb_regwrite = 0; exmem_rd = 0; memwb_rd = 0;
        exmem_result = 0; memwb_result = 0;
    endtask

    task automatic set_instr(input logic [1:0] aluop, input logic [5:0] funct,
                             input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                             input logic [31:0] rsv, input logic [31:0] rtv, input bit rw);
        id_valid = 1; id_aluop = aluop; id_funct = funct;
        id_rs = rs; id_rt = rt; id_rd = rd; id_rs_val = rsv; id_rt_val = rtv; id_regwrite = rw;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("DataA", DataA, e.a);
                chk("DataB", DataB, e.b);
                chk("store_data", ex_store_data, e.sd);
                chk("Operation", 32'(Operation), 32'(e.op));
                chk("BRANCH_EQ_NQ", 32'(BRANCH_EQ_NQ), 32'(e.br));
                chk("ex_valid", 32'(ex_valid), 32'(e.v));
                chk("ex_regwrite", 32'(ex_regwrite), 32'(e.rw));
                chk("ex_rd", 32'(ex_rd), 32'(e.rd));
            end
        end
    end

    initial begin : stimulus
        idle();
        rst = 1;
        @(negedge clk);
        repeat (3) cycle();

        // R-type sub
        idle();
        set_instr(2'b10, 6'b100010, 5'd1, 5'd2, 5'd5, 32'd9, 32'd4, 1);
        cycle();
        idle();
        cycle();

        // ori with zero- then sign-extended immediate
        set_instr(2'b11, 6'b0, 5'd1, 5'd2, 5'd6, 32'd7, 32'd8, 1);
        id_alu_src = 1; id_imm16 = 16'h8001; id_zext = 1;
        cycle();
        id_zext = 0;
        cycle();
        idle();
        cycle();

        // forwarding priority on rs=rt=3
        set_instr(2'b10, 6'b100000, 5'd3, 5'd3, 5'd7, 32'h5, 32'h6, 1);
        cycle();
        idle();
        exmem_regwrite = 1; exmem_rd = 3; exmem_result = 32'h11;
        memwb_regwrite = 1; memwb_rd = 3; memwb_result = 32'h22;
        cycle();
        exmem_regwrite = 0;
        cycle();
        exmem_regwrite = 1; exmem_rd = 0; memwb_rd = 0;
        cycle();

        // stall for three cycles with a flush in the middle one
        idle();
        set_instr(2'b10, 6'b101010, 5'd4, 5'd5, 5'd8, 32'h77, 32'h88, 1);
        cycle();
        set_instr(2'b10, 6'b100111, 5'd9, 5'd10, 5'd11, 32'h1234, 32'h5678, 1);
        stall = 1;
        cycle();
        flush = 1;
        cycle();
        flush = 0;
        cycle();
        stall = 0; id_valid = 0;
        cycle();

        // illegal funct, then beq / bne
        idle();
        set_instr(2'b10, 6'b111111, 5'd1, 5'd2, 5'd12, 32'h3, 32'h4, 1);
        cycle();
        set_instr(2'b01, 6'b0, 5'd1, 5'd2, 5'd0, 32'h3, 32'h4, 0);
        id_branch_ne = 0;
        cycle();
        id_branch_ne = 1;
        cycle();

        // reset while stalled
        idle();
        set_instr(2'b10, 6'b100100, 5'd2, 5'd3, 5'd13, 32'hAA, 32'hBB, 1);
        cycle();
        stall = 1; rst = 1;
        cycle();
        rst = 0;
        cycle();
        idle();
        cycle();

        for (int i = 0; i < 400; i++) begin
            rst            = ($urandom_range(0, 49) == 0);
            flush          = ($urandom_range(0, 9) == 0);
            stall          = ($urandom_range(0, 5) == 0);
            id_valid       = $urandom_range(0, 1);
            id_rs          = 5'($urandom_range(0, 3));
            id_rt          = 5'($urandom_range(0, 3));
            id_rd          = 5'($urandom_range(0, 31));
            id_rs_val      = $urandom;
            id_rt_val      = $urandom;
            id_imm16       = 16'($urandom);
            id_aluop       = 2'($urandom_range(0, 3));
            id_funct       = ($urandom_range(0, 3) == 0) ? 6'($urandom) : 6'(6'b100000 + $urandom_range(0, 10));
            id_alu_src     = $urandom_range(0, 1);
            id_zext        = $urandom_range(0, 1);
            id_branch_ne   = $urandom_range(0, 1);
            id_regwrite    = $urandom_range(0, 1);
            exmem_regwrite = $urandom_range(0, 1);
            memwb_regwrite = $urandom_range(0, 1);
            exmem_rd       = 5'($urandom_range(0, 3));
            memwb_rd       = 5'($urandom_range(0, 3));
            exmem_result   = $urandom;
            memwb_result   = $urandom;
            cycle();
        end

        idle();
        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
        #3;
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
